pwl_activation_pipe: RTL and testbench

//  Pipelined, multi-lane piecewise-linear (PWL) activation unit for the GRU datapath.

---
 rtl/pwl_activation_pipe.sv | 151 +++++++++++++++
 tb/tb_pwl_activation_pipe.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pwl_activation_pipe.sv
// rtl/pwl_activation_pipe.sv - 3-stage multi-lane piecewise-linear sigmoid/tanh unit
// Optional macro PWL_ROUND_EN: round-half-up slope shifts (default: floor shifts).
module pwl_activation_pipe #(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 8,
    parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH,
    parameter int LANES      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [LANES*WIDTH-1:0] in_x,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_y,
    output logic                   out_mode
);
    localparam int IW = WIDTH + 2;
    localparam int Q  = 1 << FRAC_WIDTH;

    localparam logic signed [IW-1:0] ONE   = IW'(Q);
    localparam logic signed [IW-1:0] X_MAX = IW'((1 << (WIDTH-1)) - 1);
    localparam logic signed [IW-1:0] X_MIN = IW'(-(1 << (WIDTH-1)));

    // Segment breakpoints: -5, -2.375, -1, 1, 2.375, 5
    localparam logic signed [IW-1:0] BP_0 = IW'(-5 * Q);
    localparam logic signed [IW-1:0] BP_1 = IW'(-(19 * Q) / 8);
    localparam logic signed [IW-1:0] BP_2 = IW'(-Q);
    localparam logic signed [IW-1:0] BP_3 = IW'(Q);
    localparam logic signed [IW-1:0] BP_4 = IW'((19 * Q) / 8);
    localparam logic signed [IW-1:0] BP_5 = IW'(5 * Q);

    localparam logic signed [IW-1:0] OFF_1 = IW'((5 * Q) / 32);
    localparam logic signed [IW-1:0] OFF_2 = IW'((3 * Q) / 8);
    localparam logic signed [IW-1:0] OFF_3 = IW'(Q / 2);
    localparam logic signed [IW-1:0] OFF_4 = IW'((5 * Q) / 8);
    localparam logic signed [IW-1:0] OFF_5 = IW'((27 * Q) / 32);

    function automatic logic signed [IW-1:0] sra_k(input logic signed [IW-1:0] v, input int k);
`ifdef PWL_ROUND_EN
        return (v + (IW'(1) <<< (k - 1))) >>> k;
`else
        return v >>> k;
`endif
    endfunction

    logic                 stall;
    logic                 s1_valid, s2_valid;
    logic                 s1_mode, s2_mode;
    logic signed [IW-1:0] s1_xs    [LANES];
    logic [2:0]           s1_seg   [LANES];
    logic signed [IW-1:0] s2_slope [LANES];
    logic [2:0]           s2_seg   [LANES];

    logic signed [IW-1:0]   xs_d    [LANES];
    logic [2:0]             seg_d   [LANES];
    logic signed [IW-1:0]   slope_d [LANES];
    logic signed [IW-1:0]   acc     [LANES];
    logic [LANES*WIDTH-1:0] y_d;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // S1: tanh(x) is evaluated as 2*sigmoid(2x)-1, so tanh doubles the input here
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            xs_d[i] = {{2{in_x[i*WIDTH+WIDTH-1]}}, in_x[i*WIDTH +: WIDTH]};
            if (in_mode) begin
                xs_d[i] = xs_d[i] <<< 1;
                if (xs_d[i] > X_MAX)      xs_d[i] = X_MAX;
                else if (xs_d[i] < X_MIN) xs_d[i] = X_MIN;
            end
            if      (xs_d[i] <= BP_0) seg_d[i] = 3'd0;
            else if (xs_d[i] <= BP_1) seg_d[i] = 3'd1;
            else if (xs_d[i] <= BP_2) seg_d[i] = 3'd2;
            else if (xs_d[i] <= BP_3) seg_d[i] = 3'd3;
            else if (xs_d[i] <= BP_4) seg_d[i] = 3'd4;
            else if (xs_d[i] <= BP_5) seg_d[i] = 3'd5;
            else                      seg_d[i] = 3'd6;
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            case (s1_seg[i])
                3'd1, 3'd5: slope_d[i] = sra_k(s1_xs[i], 5);
                3'd2, 3'd4: slope_d[i] = sra_k(s1_xs[i], 3);
                3'd3:       slope_d[i] = sra_k(s1_xs[i], 2);
                default:    slope_d[i] = '0;
            endcase
        end
    end

    always_comb begin
        y_d = '0;
        for (int i = 0; i < LANES; i++) begin
            case (s2_seg[i])
                3'd1:    acc[i] = OFF_1;
                3'd2:    acc[i] = OFF_2;
                3'd3:    acc[i] = OFF_3;
                3'd4:    acc[i] = OFF_4;
                3'd5:    acc[i] = OFF_5;
                3'd6:    acc[i] = ONE;
                default: acc[i] = '0;
            endcase
            acc[i] = acc[i] + s2_slope[i];
            if (acc[i] < 0)        acc[i] = '0;
            else if (acc[i] > ONE) acc[i] = ONE;
            if (s2_mode) begin
                acc[i] = (acc[i] <<< 1) - ONE;
                if (acc[i] < -ONE)     acc[i] = -ONE;
                else if (acc[i] > ONE) acc[i] = ONE;
            end
            y_d[i*WIDTH +: WIDTH] = acc[i][WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_mode   <= 1'b0;
            s2_mode   <= 1'b0;
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            out_y     <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_xs[i]    <= '0;
                s1_seg[i]   <= '0;
                s2_slope[i] <= '0;
                s2_seg[i]   <= '0;
            end
        end else if (!stall) begin
            s1_valid  <= in_valid;
            s1_mode   <= in_mode;
            s2_valid  <= s1_valid;
            s2_mode   <= s1_mode;
            out_valid <= s2_valid;
            out_mode  <= s2_mode;
            out_y     <= y_d;
            for (int i = 0; i < LANES; i++) begin
                s1_xs[i]    <= xs_d[i];
                s1_seg[i]   <= seg_d[i];
                s2_slope[i] <= slope_d[i];
                s2_seg[i]   <= s1_seg[i];
            end
        end
    end
endmodule

// File: tb/tb_pwl_activation_pipe.sv
// tb/tb_pwl_activation_pipe.sv - directed self-checking bench for pwl_activation_pipe
module tb_pwl_activation_pipe;
    localparam int W = 16;
    localparam int L = 4;
`ifdef PWL_ROUND_EN
    localparam int Y601 = 21;
`else
    localparam int Y601 = 20;
`endif

    logic           clk = 1'b0;
    logic           reset, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
    logic [L*W-1:0] in_x, out_y, held;
    int             n_cmp = 0, n_bad = 0;
    int             tx, rx, seen;
    logic           was_stall;
    int             xt [8] = '{0, 256, -256, -1280, 1281, -608, 608, 1280};
    int             yt [8] = '{128, 192, 64, 0, 256, 21, 236, 256};

    always #5 clk = ~clk;

    pwl_activation_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_mode(out_mode)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [L*W-1:0] pack(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    task automatic run_single(input string tag, input logic m,
                              input int x0, input int x1, input int x2, input int x3,
                              input int y0, input int y1, input int y2, input int y3);
        int lat;
        int ye [4];
        ye = '{y0, y1, y2, y3};
        @(negedge clk);
        out_ready = 1'b1;
        in_mode   = m;
        in_x      = pack(x0, x1, x2, x3);
        in_valid  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                in_valid = 1'b0;
                in_mode  = 1'b0;
                in_x     = '0;
            end
        end while (!out_valid && lat < 10);
        check({tag, " latency"}, lat, 3);
        for (int i = 0; i < L; i++)
            check($sformatf("%s y[%0d]", tag, i), $signed(out_y[i*W +: W]), ye[i]);
        check({tag, " mode"}, out_mode, m);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_x = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_y", (out_y == '0), 1);
        check("reset out_mode", out_mode, 0);
        check("reset in_ready", in_ready, 1);

        run_single("sigmoid basic", 1'b0, 0, 256, -1280, 1281, 128, 192, 0, 256);
        run_single("tanh basic", 1'b1, 0, 256, -128, 32767, 0, 192, -128, 256);
        run_single("sigmoid -601", 1'b0, -601, -601, -601, -601, Y601, Y601, Y601, Y601);
        run_single("sweep lo", 1'b0, -1280, -608, -256, 256, 0, 21, 64, 192);
        run_single("sweep hi", 1'b0, 608, 1280, 0, 0, 236, 256, 128, 128);

        // back-to-back stream with a 3-cycle downstream stall
        tx = 0; rx = 0; was_stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (tx < 8);
            in_mode   = 1'b0;
            in_x      = pack(xt[tx%8], xt[(tx+1)%8], xt[(tx+2)%8], xt[(tx+3)%8]);
            #1;
            if (was_stall) check("stall out_y stable", (out_y === held), 1);
            if (cyc >= 4 && cyc <= 6) check("stall in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                for (int l = 0; l < L; l++)
                    check($sformatf("stream beat %0d y[%0d]", rx, l), $signed(out_y[l*W +: W]), yt[(rx+l)%8]);
                check($sformatf("stream beat %0d mode", rx), out_mode, 0);
                rx++;
            end
            was_stall = out_valid && !out_ready;
            held      = out_y;
            if (in_valid && in_ready) tx++;
        end
        check("stream beats received", rx, 8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("stream no extra beats", seen, 0);

        // reset with two beats in flight
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b1; in_x = pack(256, 256, 256, 256);
        @(negedge clk);
        in_x = pack(-256, -256, -256, -256);
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset out_valid", out_valid, 0);
        check("midreset out_y", (out_y == '0), 1);
        check("midreset in_ready", in_ready, 1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midreset no emission", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
